// File: rtl/char_jump_ctrl.sv
// Vertical motion controller for a jumping character: ground, rise, apex hold, fall.
// Motion advances on frame_tick; button presses are edge-detected and held until the next tick.
module char_jump_ctrl #(
  parameter logic [8:0] START_Y    = 9'd200,
  parameter logic [4:0] JUMP_V     = 5'd6,
  parameter logic [4:0] SPRING_V   = 5'd10,
  parameter logic [4:0] VMAX       = 5'd8,
  parameter logic [1:0] APEX_TICKS = 2'd2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       frame_tick,
  input  logic       jump_btn,
  input  logic       jump,
  input  logic [8:0] floor_Y,
  output logic [8:0] char_Y,
  output logic [4:0] vel,
  output logic [1:0] state,
  output logic       airborne
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    APEX   = 2'd2,
    FALL   = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] char_y_q, char_y_d;
  logic [4:0] vel_q, vel_d;
  logic [1:0] apex_cnt_q, apex_cnt_d;
  logic       jump_btn_q;
  logic       pend_q, pend_d;
  logic       airborne_q, airborne_d;

  logic       btn_edge;
  logic       press;
  logic [9:0] fall_sum;

  assign btn_edge = jump_btn & ~jump_btn_q;
  // A press arriving on the tick cycle itself is honoured on that tick.
  assign press    = pend_q | btn_edge;
  assign fall_sum = {1'b0, char_y_q} + {5'd0, vel_q};

  always_comb begin
    state_d    = state_q;
    char_y_d   = char_y_q;
    vel_d      = vel_q;
    apex_cnt_d = apex_cnt_q;
    pend_d     = press;
    if (frame_tick) begin
      pend_d = 1'b0;
      unique case (state_q)
        GROUND: begin
          if (jump) begin
            state_d = RISE;
            vel_d   = SPRING_V;
          end else if (press) begin
            state_d = RISE;
            vel_d   = JUMP_V;
          end else if (char_y_q < floor_Y) begin
            state_d = FALL;
            vel_d   = 5'd1;
          end else begin
            char_y_d = floor_Y;
          end
        end
        RISE: begin
          char_y_d = (char_y_q > {4'd0, vel_q}) ? char_y_q - {4'd0, vel_q} : '0;
          vel_d    = (vel_q != '0) ? vel_q - 5'd1 : '0;
          if (vel_q <= 5'd1) begin
            state_d    = APEX;
            apex_cnt_d = APEX_TICKS;
          end
        end
        APEX: begin
          apex_cnt_d = (apex_cnt_q != '0) ? apex_cnt_q - 2'd1 : '0;
          if (apex_cnt_q <= 2'd1) begin
            state_d = FALL;
            vel_d   = 5'd1;
          end
        end
        FALL: begin
          // Spring contact beats landing on the same tick.
          if (jump) begin
            state_d = RISE;
            vel_d   = SPRING_V;
          end else if (fall_sum >= {1'b0, floor_Y}) begin
            state_d  = GROUND;
            char_y_d = floor_Y;
            vel_d    = '0;
          end else begin
            char_y_d = fall_sum[8:0];
            vel_d    = (vel_q >= VMAX) ? VMAX : vel_q + 5'd1;
          end
        end
        default: state_d = GROUND;
      endcase
    end
    airborne_d = (state_d != GROUND);
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= GROUND;
      char_y_q   <= START_Y;
      vel_q      <= '0;
      apex_cnt_q <= '0;
      jump_btn_q <= 1'b0;
      pend_q     <= 1'b0;
      airborne_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      char_y_q   <= char_y_d;
      vel_q      <= vel_d;
      apex_cnt_q <= apex_cnt_d;
      jump_btn_q <= jump_btn;
      pend_q     <= pend_d;
      airborne_q <= airborne_d;
    end
  end

  assign char_Y   = char_y_q;
  assign vel      = vel_q;
  assign state    = state_q;
  assign airborne = airborne_q;

endmodule
